// File: rtl/cmac_link_ctrl.sv
// Per-channel CMAC bring-up/supervision FSMs driving the static ctl_* inputs.
// Define CMAC_LINK_CTRL_STAT_EN to implement the link-drop and resync counters.
module cmac_link_ch #(
  parameter int STABLE_CYCLES = 8,
  parameter int ALIGN_TIMEOUT = 65536,
  parameter int RESYNC_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_enable,
  input  logic                 i_aligned,
  output logic                 o_rx_enable,
  output logic                 o_tx_enable,
  output logic                 o_send_rfi,
  output logic                 o_force_resync,
  output logic                 o_link_up,
  output logic [CNT_WIDTH-1:0] o_link_down_cnt,
  output logic [CNT_WIDTH-1:0] o_resync_cnt
);
  localparam int TW = $clog2(ALIGN_TIMEOUT);
  localparam int SW = $clog2(STABLE_CYCLES + 1);
  localparam int RW = $clog2(RESYNC_CYCLES + 1);
  localparam logic [TW-1:0] TMR_LAST = TW'(ALIGN_TIMEOUT - 1);
  localparam logic [SW-1:0] STB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [RW-1:0] RS_LAST  = RW'(RESYNC_CYCLES - 1);

  typedef enum logic [2:0] {
    ST_DISABLED, ST_WAIT_ALIGN, ST_SETTLE, ST_UP, ST_RESYNC
  } state_t;

  state_t        r_state, w_nxt;
  logic [TW-1:0] r_tmr;
  logic [SW-1:0] r_stb;
  logic [RW-1:0] r_rs;
  logic          w_tmr_clr, w_tmr_inc, w_stb_clr, w_stb_inc, w_rs_clr, w_rs_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_DISABLED;
    else     r_state <= w_nxt;
  end

  always_comb begin
    w_nxt     = r_state;
    w_tmr_clr = 1'b0;
    w_tmr_inc = 1'b0;
    w_stb_clr = 1'b0;
    w_stb_inc = 1'b0;
    w_rs_clr  = 1'b0;
    w_rs_inc  = 1'b0;
    if (!i_enable) begin
      w_nxt = ST_DISABLED;
    end else begin
      case (r_state)
        ST_DISABLED: begin
          w_nxt     = ST_WAIT_ALIGN;
          w_tmr_clr = 1'b1;
        end
        ST_WAIT_ALIGN: begin
          if (i_aligned) begin
            w_nxt     = ST_SETTLE;
            w_stb_clr = 1'b1;
          end else if (r_tmr == TMR_LAST) begin
            w_nxt    = ST_RESYNC;
            w_rs_clr = 1'b1;
          end else begin
            w_tmr_inc = 1'b1;
          end
        end
        ST_SETTLE: begin
          if (!i_aligned) begin
            w_nxt     = ST_WAIT_ALIGN;
            w_tmr_clr = 1'b1;
          end else if (r_stb == STB_LAST) begin
            w_nxt = ST_UP;
          end else begin
            w_stb_inc = 1'b1;
          end
        end
        ST_UP: begin
          if (!i_aligned) begin
            w_nxt     = ST_WAIT_ALIGN;
            w_tmr_clr = 1'b1;
          end
        end
        ST_RESYNC: begin
          // alignment is deliberately ignored so the pulse always completes
          if (r_rs == RS_LAST) begin
            w_nxt     = ST_WAIT_ALIGN;
            w_tmr_clr = 1'b1;
          end else begin
            w_rs_inc = 1'b1;
          end
        end
        default: w_nxt = ST_DISABLED;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmr <= '0;
      r_stb <= '0;
      r_rs  <= '0;
    end else begin
      if (w_tmr_clr)      r_tmr <= '0;
      else if (w_tmr_inc) r_tmr <= r_tmr + 1'b1;
      if (w_stb_clr)      r_stb <= '0;
      else if (w_stb_inc) r_stb <= r_stb + 1'b1;
      if (w_rs_clr)       r_rs  <= '0;
      else if (w_rs_inc)  r_rs  <= r_rs + 1'b1;
    end
  end

  assign o_rx_enable    = (r_state != ST_DISABLED);
  assign o_tx_enable    = (r_state == ST_UP);
  assign o_link_up      = (r_state == ST_UP);
  assign o_force_resync = (r_state == ST_RESYNC);
  assign o_send_rfi     = (r_state == ST_WAIT_ALIGN) || (r_state == ST_SETTLE) ||
                          (r_state == ST_RESYNC);

`ifdef CMAC_LINK_CTRL_STAT_EN
  logic                 w_down_evt, w_rs_evt;
  logic [CNT_WIDTH-1:0] r_down_cnt, r_rs_cnt;

  assign w_down_evt = (r_state == ST_UP) && (w_nxt == ST_WAIT_ALIGN);
  assign w_rs_evt   = (r_state != ST_RESYNC) && (w_nxt == ST_RESYNC);

  // saturating; disable does not clear them
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_down_cnt <= '0;
      r_rs_cnt   <= '0;
    end else begin
      if (w_down_evt && (r_down_cnt != '1)) r_down_cnt <= r_down_cnt + 1'b1;
      if (w_rs_evt && (r_rs_cnt != '1))     r_rs_cnt   <= r_rs_cnt + 1'b1;
    end
  end

  assign o_link_down_cnt = r_down_cnt;
  assign o_resync_cnt    = r_rs_cnt;
`else
  assign o_link_down_cnt = '0;
  assign o_resync_cnt    = '0;
`endif
endmodule

module cmac_link_ctrl #(
  parameter int CHANNEL_NUM   = 2,
  parameter int STABLE_CYCLES = 8,
  parameter int ALIGN_TIMEOUT = 65536,
  parameter int RESYNC_CYCLES = 4,
  parameter int CNT_WIDTH     = 16
) (
  input  logic                             cmac_rxtx_clk,
  input  logic                             cmac_reset,
  input  logic [CHANNEL_NUM-1:0]           cfg_enable,
  input  logic [CHANNEL_NUM-1:0]           stat_rx_aligned,
  output logic [CHANNEL_NUM-1:0]           ctl_rx_enable,
  output logic [CHANNEL_NUM-1:0]           ctl_tx_enable,
  output logic [CHANNEL_NUM-1:0]           ctl_tx_send_rfi,
  output logic [CHANNEL_NUM-1:0]           ctl_tx_send_lfi,
  output logic [CHANNEL_NUM-1:0]           ctl_rx_force_resync,
  output logic [CHANNEL_NUM-1:0]           link_up,
  output logic [CHANNEL_NUM*CNT_WIDTH-1:0] link_down_cnt,
  output logic [CHANNEL_NUM*CNT_WIDTH-1:0] resync_cnt
);
  assign ctl_tx_send_lfi = '0;

  for (genvar g = 0; g < CHANNEL_NUM; g++) begin : g_ch
    cmac_link_ch #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .ALIGN_TIMEOUT (ALIGN_TIMEOUT),
      .RESYNC_CYCLES (RESYNC_CYCLES),
      .CNT_WIDTH     (CNT_WIDTH)
    ) u_ch (
      .clk             (cmac_rxtx_clk),
      .rst             (cmac_reset),
      .i_enable        (cfg_enable[g]),
      .i_aligned       (stat_rx_aligned[g]),
      .o_rx_enable     (ctl_rx_enable[g]),
      .o_tx_enable     (ctl_tx_enable[g]),
      .o_send_rfi      (ctl_tx_send_rfi[g]),
      .o_force_resync  (ctl_rx_force_resync[g]),
      .o_link_up       (link_up[g]),
      .o_link_down_cnt (link_down_cnt[g*CNT_WIDTH +: CNT_WIDTH]),
      .o_resync_cnt    (resync_cnt[g*CNT_WIDTH +: CNT_WIDTH])
    );
  end
endmodule
